// File: rtl/ex_stage.sv
// Execute stage of the 16-bit encryption pipeline: single-cycle ALU plus registered EX/MEM bundle.
// Define EX_MUL_EN to build the iterative shift-add multiplier (funct4=9) and its BUSY state.
module ex_stage #(
    parameter int P = 16,
    parameter int D = 16,
    parameter int R = 4,
    parameter int F = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    input  logic [P-1:0] next_pc_i,
    input  logic [F-1:0] funct4_i,
    input  logic [D-1:0] rs_i,
    input  logic [D-1:0] rt_i,
    input  logic [R-1:0] rd_i,
    input  logic         flush_i,
    output logic         stall_o,
    output logic         valid_o,
    output logic [D-1:0] result_o,
    output logic [R-1:0] rd_o,
    output logic         we_o,
    output logic         branch_taken_o,
    output logic [P-1:0] branch_target_o
);
    localparam int SW = $clog2(D);

    localparam logic [F-1:0] OP_ADD  = F'(0);
    localparam logic [F-1:0] OP_SUB  = F'(1);
    localparam logic [F-1:0] OP_AND  = F'(2);
    localparam logic [F-1:0] OP_OR   = F'(3);
    localparam logic [F-1:0] OP_XOR  = F'(4);
    localparam logic [F-1:0] OP_SLL  = F'(5);
    localparam logic [F-1:0] OP_SRL  = F'(6);
    localparam logic [F-1:0] OP_ROL  = F'(7);
    localparam logic [F-1:0] OP_ROR  = F'(8);
    localparam logic [F-1:0] OP_BEQZ = F'(12);

    logic [SW-1:0] sh;
    logic [SW:0]   sh_inv;
    logic [D-1:0]  alu_result;
    logic          alu_we;

    logic          valid_reg,  valid_next;
    logic          we_reg,     we_next;
    logic          bt_reg,     bt_next;
    logic [D-1:0]  result_reg, result_next;
    logic [R-1:0]  rd_reg,     rd_next;
    logic [P-1:0]  target_reg, target_next;

`ifdef EX_MUL_EN
    localparam logic [F-1:0]  OP_MUL   = F'(9);
    localparam logic [SW-1:0] CNT_LAST = SW'(D - 1);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t        state_reg,  state_next;
    logic [SW-1:0] cnt_reg,    cnt_next;
    logic [D-1:0]  acc_reg,    acc_next;
    logic [D-1:0]  mcand_reg,  mcand_next;
    logic [D-1:0]  mplier_reg, mplier_next;
    logic [R-1:0]  mrd_reg,    mrd_next;
    logic [D-1:0]  acc_sum;
    logic          stall;
`endif

    // Rotates are built from two shifts; a zero amount shifts the other half fully out.
    always_comb begin
        sh         = rt_i[SW-1:0];
        sh_inv     = (SW+1)'(D) - {1'b0, sh};
        alu_result = '0;
        alu_we     = 1'b1;
        case (funct4_i)
            OP_ADD:  alu_result = rs_i + rt_i;
            OP_SUB:  alu_result = rs_i - rt_i;
            OP_AND:  alu_result = rs_i & rt_i;
            OP_OR:   alu_result = rs_i | rt_i;
            OP_XOR:  alu_result = rs_i ^ rt_i;
            OP_SLL:  alu_result = rs_i << sh;
            OP_SRL:  alu_result = rs_i >> sh;
            OP_ROL:  alu_result = (rs_i << sh) | (rs_i >> sh_inv);
            OP_ROR:  alu_result = (rs_i >> sh) | (rs_i << sh_inv);
            default: alu_we = 1'b0;
        endcase
    end

    always_comb begin
        valid_next  = 1'b0;
        we_next     = 1'b0;
        bt_next     = 1'b0;
        result_next = result_reg;
        rd_next     = rd_reg;
        target_next = target_reg;
`ifdef EX_MUL_EN
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        acc_next    = acc_reg;
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        mrd_next    = mrd_reg;
        stall       = 1'b0;
        acc_sum     = acc_reg + (mplier_reg[cnt_reg] ? (mcand_reg << cnt_reg) : '0);
`endif
        if (flush_i) begin
`ifdef EX_MUL_EN
            state_next = IDLE;
            cnt_next   = '0;
`endif
        end else
`ifdef EX_MUL_EN
        if (state_reg == BUSY) begin
            // The last iteration lets upstream advance so the next op lands right behind the result.
            acc_next = acc_sum;
            cnt_next = cnt_reg + 1'b1;
            stall    = (cnt_reg != CNT_LAST);
            if (cnt_reg == CNT_LAST) begin
                valid_next  = 1'b1;
                we_next     = 1'b1;
                result_next = acc_sum;
                rd_next     = mrd_reg;
                state_next  = IDLE;
                cnt_next    = '0;
            end
        end else if (valid_i && funct4_i == OP_MUL) begin
            stall       = 1'b1;
            state_next  = BUSY;
            cnt_next    = '0;
            acc_next    = '0;
            mcand_next  = rs_i;
            mplier_next = rt_i;
            mrd_next    = rd_i;
        end else
`endif
        if (valid_i) begin
            valid_next  = 1'b1;
            we_next     = alu_we;
            result_next = alu_result;
            rd_next     = rd_i;
            bt_next     = (funct4_i == OP_BEQZ) && (rs_i == '0);
            target_next = next_pc_i + P'(rt_i);
        end
`ifdef EX_MUL_EN
        if (rst_i) begin
            stall = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_reg  <= 1'b0;
            we_reg     <= 1'b0;
            bt_reg     <= 1'b0;
            result_reg <= '0;
            rd_reg     <= '0;
            target_reg <= '0;
`ifdef EX_MUL_EN
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            mrd_reg    <= '0;
`endif
        end else begin
            valid_reg  <= valid_next;
            we_reg     <= we_next;
            bt_reg     <= bt_next;
            result_reg <= result_next;
            rd_reg     <= rd_next;
            target_reg <= target_next;
`ifdef EX_MUL_EN
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            mrd_reg    <= mrd_next;
`endif
        end
    end

`ifdef EX_MUL_EN
    assign stall_o = stall;
`else
    assign stall_o = 1'b0;
`endif
    assign valid_o         = valid_reg;
    assign we_o            = we_reg;
    assign branch_taken_o  = bt_reg;
    assign result_o        = result_reg;
    assign rd_o            = rd_reg;
    assign branch_target_o = target_reg;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: expected EX/MEM bundles are queued at issue and checked when valid_o fires.
// Multiplier scenarios follow EX_MUL_EN exactly as the design does.
module tb_ex_stage;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [15:0] next_pc_i;
    logic [3:0]  funct4_i;
    logic [15:0] rs_i;
    logic [15:0] rt_i;
    logic [3:0]  rd_i;
    logic        flush_i;
    logic        stall_o;
    logic        valid_o;
    logic [15:0] result_o;
    logic [3:0]  rd_o;
    logic        we_o;
    logic        branch_taken_o;
    logic [15:0] branch_target_o;

    typedef struct {
        logic [15:0] res;
        logic [3:0]  rd;
        logic        we;
        logic        bt;
        logic [15:0] tgt;
        bit          chk_res;
        int          due;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .next_pc_i(next_pc_i),
        .funct4_i(funct4_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i), .flush_i(flush_i),
        .stall_o(stall_o), .valid_o(valid_o), .result_o(result_o), .rd_o(rd_o), .we_o(we_o),
        .branch_taken_o(branch_taken_o), .branch_target_o(branch_target_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        int n;
        n = int'(b[3:0]);
        r = 16'h0;
        case (f)
            4'd0: r = a + b;
            4'd1: r = a + ~b + 16'd1;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: for (int k = 0; k < 16; k++) r[k] = (k >= n) ? a[k-n] : 1'b0;
            4'd6: for (int k = 0; k < 16; k++) r[k] = (k + n < 16) ? a[k+n] : 1'b0;
            4'd7: begin r = a; for (int k = 0; k < n; k++) r = {r[14:0], r[15]}; end
            4'd8: begin r = a; for (int k = 0; k < n; k++) r = {r[0], r[15:1]}; end
            default: r = 16'h0;
        endcase
        return r;
    endfunction

    // Upstream model: present an instruction, hold it while stall_o is high, then retire it.
    task automatic issue(input string tag, input logic [3:0] f, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] d, input logic [15:0] pc, input logic [15:0] er,
                         input logic ewe, input logic ebt, input logic [15:0] etgt,
                         input bit chk_res, input int lat, input int exp_stalls);
        exp_t e;
        int stalls;
        valid_i = 1'b1; funct4_i = f; rs_i = a; rt_i = b; rd_i = d; next_pc_i = pc;
        e.res = er; e.rd = d; e.we = ewe; e.bt = ebt; e.tgt = etgt;
        e.chk_res = chk_res; e.due = cyc + lat; e.tag = tag;
        sb.push_back(e);
        stalls = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_i);
            if (stall_o !== 1'b1) break;
            stalls++;
        end
        check({tag, "_stall_cycles"}, stalls, exp_stalls);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_i = 1'b0;
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Output monitor: every valid_o must match the oldest queued expectation, in its due cycle.
    always @(negedge clk_i) begin
        exp_t e;
        if (cyc > 0) begin
            if (valid_o === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check({e.tag, "_cycle"}, cyc, e.due);
                    check({e.tag, "_rd"}, rd_o, e.rd);
                    check({e.tag, "_we"}, we_o, e.we);
                    check({e.tag, "_branch_taken"}, branch_taken_o, e.bt);
                    if (e.chk_res) check({e.tag, "_result"}, result_o, e.res);
                    if (e.bt) check({e.tag, "_target"}, branch_target_o, e.tgt);
                end
            end else begin
                check("idle_we", we_o, 0);
                check("idle_branch_taken", branch_taken_o, 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  codes [14];
        logic [15:0] a, b, r;
        codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10, 4'd11, 4'd13, 4'd14, 4'd15};

        // Reset held with a live ADD on the inputs
        rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b1;
        funct4_i = 4'd0; rs_i = 16'd3; rt_i = 16'd5; rd_i = 4'd1; next_pc_i = 16'd0;
        repeat (3) begin
            @(negedge clk_i);
            check("rst_valid", valid_o, 0);
            check("rst_result", result_o, 0);
            check("rst_rd", rd_o, 0);
            check("rst_we", we_o, 0);
            check("rst_bt", branch_taken_o, 0);
            check("rst_target", branch_target_o, 0);
            check("rst_stall", stall_o, 0);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        issue("add_3_5", 4'd0, 16'd3, 16'd5, 4'd1, 16'd0, 16'h0008, 1'b1, 1'b0, 16'h0, 1'b1, 1, 0);
        issue("sub_2_5", 4'd1, 16'd2, 16'd5, 4'd2, 16'd0, 16'hFFFD, 1'b1, 1'b0, 16'h0, 1'b1, 1, 0);
        issue("rol_8001", 4'd7, 16'h8001, 16'd1, 4'd3, 16'd0, 16'h0003, 1'b1, 1'b0, 16'h0, 1'b1, 1, 0);
        issue("xor_ff00", 4'd4, 16'hFF00, 16'h0FF0, 4'd4, 16'd0, 16'hF0F0, 1'b1, 1'b0, 16'h0, 1'b1, 1, 0);
        issue("ror_0001", 4'd8, 16'h0001, 16'd4, 4'd5, 16'd0, 16'h1000, 1'b1, 1'b0, 16'h0, 1'b1, 1, 0);
        idle(2);

        // Remaining codes against the reference model, back-to-back
        for (int i = 0; i < 14; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            r = model(codes[i], a, b);
            issue($sformatf("op%0d", codes[i]), codes[i], a, b, 4'(i), 16'd0, r,
                  (codes[i] <= 4'd8), 1'b0, 16'h0, (codes[i] <= 4'd8), 1, 0);
        end
        idle(2);

        // Branches
        issue("beqz_taken", 4'd12, 16'd0, 16'hFFFE, 4'd9, 16'd42, 16'h0, 1'b0, 1'b1, 16'd40, 1'b0, 1, 0);
        issue("beqz_not_taken", 4'd12, 16'd1, 16'hFFFE, 4'd9, 16'd42, 16'h0, 1'b0, 1'b0, 16'd40, 1'b0, 1, 0);
        issue("beqz_wrap", 4'd12, 16'd0, 16'h0010, 4'd9, 16'hFFF8, 16'h0, 1'b0, 1'b1, 16'h0008, 1'b0, 1, 0);
        idle(2);

`ifdef EX_MUL_EN
        issue("mul_300_7", 4'd9, 16'd300, 16'd7, 4'd5, 16'd0, 16'h0834, 1'b1, 1'b0, 16'h0, 1'b1, 17, 16);
        issue("add_after_mul", 4'd0, 16'd1, 16'd1, 4'd6, 16'd0, 16'h0002, 1'b1, 1'b0, 16'h0, 1'b1, 1, 0);
        idle(2);
        issue("mul_1234", 4'd9, 16'h1234, 16'h0100, 4'd7, 16'd0, 16'h3400, 1'b1, 1'b0, 16'h0, 1'b1, 17, 16);
        idle(2);

        // Flush while BUSY at cnt=7
        valid_i = 1'b1; funct4_i = 4'd9; rs_i = 16'd300; rt_i = 16'd7; rd_i = 4'd6;
        @(negedge clk_i);
        check("flushmul_stall_accept", stall_o, 1);
        repeat (8) @(posedge clk_i);
        #1;
        check("flushmul_stall_cnt7", stall_o, 1);
        flush_i = 1'b1; valid_i = 1'b0;
        #1;
        check("flushmul_stall_drop", stall_o, 0);
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        check("flushmul_stall_after", stall_o, 0);
        idle(20);
        issue("add_after_flush", 4'd0, 16'd4, 16'd4, 4'd2, 16'd0, 16'h0008, 1'b1, 1'b0, 16'h0, 1'b1, 1, 0);

        // Reset in the middle of a multiply
        valid_i = 1'b1; funct4_i = 4'd9; rs_i = 16'd300; rt_i = 16'd7; rd_i = 4'd7;
        repeat (4) @(posedge clk_i);
        #1;
        rst_i = 1'b1; valid_i = 1'b0;
        @(posedge clk_i); #1;
        check("rstmul_stall", stall_o, 0);
        check("rstmul_valid", valid_o, 0);
        check("rstmul_result", result_o, 0);
        check("rstmul_rd", rd_o, 0);
        check("rstmul_we", we_o, 0);
        rst_i = 1'b0;
        idle(20);
        issue("add_after_rst", 4'd0, 16'd9, 16'd1, 4'd3, 16'd0, 16'h000A, 1'b1, 1'b0, 16'h0, 1'b1, 1, 0);
`else
        issue("mul_as_nop", 4'd9, 16'd300, 16'd7, 4'd5, 16'd0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1, 0);
        issue("add_after_nop", 4'd0, 16'd1, 16'd1, 4'd6, 16'd0, 16'h0002, 1'b1, 1'b0, 16'h0, 1'b1, 1, 0);
`endif
        idle(2);

        // Flush together with a MUL accept or an ALU op: nothing issues, no stall
        valid_i = 1'b1; funct4_i = 4'd9; rs_i = 16'd5; rt_i = 16'd5; rd_i = 4'd1; flush_i = 1'b1;
        #1;
        check("flush_mul_stall", stall_o, 0);
        @(posedge clk_i); #1;
        funct4_i = 4'd0;
        #1;
        check("flush_add_stall", stall_o, 0);
        @(posedge clk_i); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        check("flush_idle_stall", stall_o, 0);
        check("flush_valid", valid_o, 0);
        idle(3);
        issue("add_after_flush2", 4'd3, 16'h00F0, 16'h000F, 4'd4, 16'd0, 16'h00FF, 1'b1, 1'b0, 16'h0, 1'b1, 1, 0);

        idle(25);
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
